// File: rtl/ss_dma_rd_if.sv
// Bundles the command, Wishbone master, output stream and status signals of the DMA read engine.
// master = the engine itself, slave = the surrounding bridge/datapath.
interface ss_dma_rd_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_adr;
  logic [15:0] cmd_len;

  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_cab_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_rty_i;
  logic        wbm_err_i;

  logic        dat_valid;
  logic        dat_ready;
  logic [31:0] dat_o;
  logic        dat_last;
  logic        done_o;
  logic        done_err;

  modport master (
    input  cmd_valid, cmd_adr, cmd_len,
    output cmd_ready,
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cab_o,
    input  wbm_dat_i, wbm_ack_i, wbm_rty_i, wbm_err_i,
    output dat_valid, dat_o, dat_last, done_o, done_err,
    input  dat_ready
  );

  modport slave (
    output cmd_valid, cmd_adr, cmd_len,
    input  cmd_ready,
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_cab_o,
    output wbm_dat_i, wbm_ack_i, wbm_rty_i, wbm_err_i,
    input  dat_valid, dat_o, dat_last, done_o, done_err,
    output dat_ready
  );
endinterface

// File: rtl/ss_dma_rd.sv
// DMA read engine: splits a (address, word count) command into Wishbone read bursts
// bounded by MAX_BURST and 4 KB pages, retries on rty, and streams the words out.
module ss_dma_rd #(
  parameter int MAX_BURST = 16,
  parameter int RTY_MAX   = 8
) (
  input logic         wb_clk_i,
  input logic         wb_rst_n,
  ss_dma_rd_if.master bus
);

  typedef enum logic [1:0] {IDLE, GAP, BURST, DONE} state_t;

  state_t      state;
  logic [31:0] adr;
  logic [16:0] rem;
  logic [16:0] bcnt;
  logic [7:0]  rty_cnt;
  logic        err_flag;
  logic        cmd_rdy;
  logic        cyc;
  logic        cab;
  logic [31:0] dat_q;
  logic        dat_vld;
  logic        last_q;
  logic        done_q;
  logic        done_err_q;

  logic [16:0] room;
  logic [16:0] blen;
  logic        stb;
  logic        err_hit;
  logic        rty_hit;
  logic        ack_hit;
  logic        drain;
  logic [7:0]  rty_next;

  // Next burst length: limited by remaining words, MAX_BURST and the words left in this 4 KB page
  always_comb begin
    room = 17'd1024 - {7'd0, adr[11:2]};
    blen = rem;
    if (blen > 17'(MAX_BURST)) blen = 17'(MAX_BURST);
    if (blen > room) blen = room;
  end

  // The strobe stalls while the output word is still waiting for the consumer
  assign stb      = cyc & (~dat_vld | bus.dat_ready);
  assign err_hit  = stb & bus.wbm_err_i;
  assign rty_hit  = stb & bus.wbm_rty_i & ~bus.wbm_err_i;
  assign ack_hit  = stb & bus.wbm_ack_i & ~bus.wbm_rty_i & ~bus.wbm_err_i;
  assign drain    = dat_vld & bus.dat_ready;
  assign rty_next = rty_cnt + 8'd1;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      adr        <= '0;
      rem        <= '0;
      bcnt       <= '0;
      rty_cnt    <= '0;
      err_flag   <= 1'b0;
      cmd_rdy    <= 1'b0;
      cyc        <= 1'b0;
      cab        <= 1'b0;
      dat_q      <= '0;
      dat_vld    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;

      // A drain and a new ack in the same cycle simply reload the output register
      if (ack_hit) begin
        dat_q   <= bus.wbm_dat_i;
        dat_vld <= 1'b1;
        last_q  <= (rem == 17'd1);
      end else if (drain) begin
        dat_vld <= 1'b0;
        last_q  <= 1'b0;
      end

      case (state)
        IDLE: begin
          cmd_rdy <= 1'b1;
          if (bus.cmd_valid && cmd_rdy) begin
            cmd_rdy  <= 1'b0;
            adr      <= bus.cmd_adr & ~32'd3;
            rem      <= {(bus.cmd_len == 16'd0), bus.cmd_len};
            rty_cnt  <= '0;
            err_flag <= 1'b0;
            state    <= GAP;
          end
        end
        GAP: begin
          bcnt  <= blen;
          cab   <= (blen > 17'd1);
          cyc   <= 1'b1;
          state <= BURST;
        end
        BURST: begin
          if (err_hit) begin
            err_flag <= 1'b1;
            cyc      <= 1'b0;
            state    <= DONE;
          end else if (rty_hit) begin
            // A retried burst restarts from the current adr/rem, so nothing is repeated
            rty_cnt <= rty_next;
            cyc     <= 1'b0;
            if (rty_next == 8'(RTY_MAX)) begin
              err_flag <= 1'b1;
              state    <= DONE;
            end else begin
              state <= GAP;
            end
          end else if (ack_hit) begin
            adr     <= adr + 32'd4;
            rem     <= rem - 17'd1;
            bcnt    <= bcnt - 17'd1;
            rty_cnt <= '0;
            if (bcnt == 17'd1) begin
              cyc   <= 1'b0;
              state <= (rem == 17'd1) ? DONE : GAP;
            end
          end
        end
        DONE: begin
          if (!dat_vld || bus.dat_ready) begin
            done_q     <= 1'b1;
            done_err_q <= err_flag;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_rdy;
  assign bus.wbm_adr_o = adr;
  assign bus.wbm_dat_o = '0;
  assign bus.wbm_sel_o = 4'hf;
  assign bus.wbm_we_o  = 1'b0;
  assign bus.wbm_cyc_o = cyc;
  assign bus.wbm_stb_o = stb;
  assign bus.wbm_cab_o = cyc & cab;
  assign bus.dat_valid = dat_vld;
  assign bus.dat_o     = dat_q;
  assign bus.dat_last  = last_q;
  assign bus.done_o    = done_q;
  assign bus.done_err  = done_err_q;

endmodule

// File: tb/tb_ss_dma_rd.sv
// Directed bench for ss_dma_rd: a scripted Wishbone slave returns adr^KEY as data
// and can inject rty/err on a chosen strobe; a negedge monitor records bursts and words.
module tb_ss_dma_rd;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic clk;
  logic rst_n;
  ss_dma_rd_if bus();

  ss_dma_rd #(.MAX_BURST(16), .RTY_MAX(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  int stb_cnt = 0;
  int rty_at = -1;
  int err_at = -1;
  bit rty_all = 1'b0;

  // Scripted zero-wait slave; stb_cnt numbers the strobes of the current command
  always_comb begin
    bus.wbm_ack_i = 1'b0;
    bus.wbm_rty_i = 1'b0;
    bus.wbm_err_i = 1'b0;
    bus.wbm_dat_i = bus.wbm_adr_o ^ KEY;
    if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
      if (rty_all || stb_cnt == rty_at) bus.wbm_rty_i = 1'b1;
      else if (stb_cnt == err_at)       bus.wbm_err_i = 1'b1;
      else                              bus.wbm_ack_i = 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (bus.cmd_valid && bus.cmd_ready) stb_cnt <= 0;
      else if (bus.wbm_cyc_o && bus.wbm_stb_o) stb_cnt <= stb_cnt + 1;
    end
  end

  logic [31:0] words[$];
  bit          lasts[$];
  logic [31:0] badr[$];
  bit          bcab[$];
  int          blens[$];
  int cyc_idx = 0;
  int done_cnt = 0;
  bit done_err_seen = 1'b0;
  int rty_seen = 0;
  int bp_viol = 0;
  int cyc_cycles = 0;
  int accept_cyc = 0;
  int first_stb_cyc = -1;
  int consume_cyc = 0;
  int done_cyc = 0;
  bit ready_probe = 1'b0;
  bit ready_after_done = 1'b0;
  bit cyc_prev = 1'b0;

  // Monitor samples mid-cycle, after the bench's inputs have settled
  initial begin
    forever begin
      @(negedge clk);
      cyc_idx++;
      if (bus.cmd_valid && bus.cmd_ready) begin
        words.delete(); lasts.delete(); badr.delete(); bcab.delete(); blens.delete();
        done_cnt = 0; done_err_seen = 0; rty_seen = 0; bp_viol = 0; cyc_cycles = 0;
        accept_cyc = cyc_idx; first_stb_cyc = -1;
      end
      if (ready_probe) begin
        ready_after_done = bus.cmd_ready;
        ready_probe = 1'b0;
      end
      if (bus.done_o) begin
        done_cnt++;
        done_err_seen = bus.done_err;
        done_cyc = cyc_idx;
        ready_probe = 1'b1;
      end
      if (bus.dat_valid && bus.dat_ready) begin
        words.push_back(bus.dat_o);
        lasts.push_back(bus.dat_last);
        consume_cyc = cyc_idx;
      end
      if (bus.dat_valid && !bus.dat_ready && bus.wbm_stb_o) bp_viol++;
      if (bus.wbm_cyc_o) begin
        cyc_cycles++;
        if (!cyc_prev) begin
          badr.push_back(bus.wbm_adr_o);
          bcab.push_back(bus.wbm_cab_o);
          blens.push_back(0);
        end
        if (bus.wbm_stb_o && first_stb_cyc < 0) first_stb_cyc = cyc_idx;
        if (bus.wbm_stb_o && bus.wbm_ack_i)
          blens[blens.size()-1] = blens[blens.size()-1] + 1;
        if (bus.wbm_stb_o && bus.wbm_rty_i) rty_seen++;
      end
      cyc_prev = bus.wbm_cyc_o;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] adr, input logic [15:0] len, input string tag);
    int n = 0;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_adr   = adr;
    bus.cmd_len   = len;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    checkOutput({tag, "_accept_timeout"}, 32'(n >= 50), 32'd0);
  endtask

  task automatic waitDone(input bit toggle, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(posedge clk);
      #1;
      if (toggle) bus.dat_ready = ~bus.dat_ready;
      n++;
    end
    bus.dat_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_done_timeout"}, 32'(n >= 2000), 32'd0);
  endtask

  // Checks word count and that word i carries (start + 4*i) ^ KEY
  task automatic checkWords(input string tag, input logic [31:0] start, input int n_exp);
    int bad = 0;
    logic [31:0] a;
    for (int i = 0; i < words.size(); i++) begin
      a = start + 32'(4 * i);
      if (words[i] !== (a ^ KEY)) bad++;
    end
    checkOutput({tag, "_nwords"}, 32'(words.size()), 32'(n_exp));
    checkOutput({tag, "_bad_words"}, 32'(bad), 32'd0);
  endtask

  function automatic int countLasts();
    int c = 0;
    foreach (lasts[i]) if (lasts[i]) c++;
    return c;
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_adr   = '0;
    bus.cmd_len   = '0;
    bus.dat_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    checkOutput("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    checkOutput("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    checkOutput("rst_dat_valid", 32'(bus.dat_valid), 32'd0);
    checkOutput("rst_done", 32'(bus.done_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_ready_after", 32'(bus.cmd_ready), 32'd1);

    // Single word with timing
    applyStimulus(32'h0000_1000, 16'd1, "single");
    waitDone(1'b0, "single");
    checkWords("single", 32'h0000_1000, 1);
    checkOutput("single_last", 32'(countLasts()), 32'd1);
    checkOutput("single_nbursts", 32'(blens.size()), 32'd1);
    checkOutput("single_cab", 32'(bcab[0]), 32'd0);
    checkOutput("single_cyc_cycles", 32'(cyc_cycles), 32'd1);
    checkOutput("single_stb_latency", 32'(first_stb_cyc - accept_cyc), 32'd2);
    checkOutput("single_done_latency", 32'(done_cyc - consume_cyc), 32'd1);
    checkOutput("single_done_err", 32'(done_err_seen), 32'd0);
    checkOutput("single_ready_after_done", 32'(ready_after_done), 32'd1);

    // Burst split at the 4 KB page and MAX_BURST
    applyStimulus(32'h0000_0FE0, 16'd40, "split");
    waitDone(1'b0, "split");
    checkWords("split", 32'h0000_0FE0, 40);
    checkOutput("split_nbursts", 32'(blens.size()), 32'd3);
    checkOutput("split_len0", 32'(blens[0]), 32'd8);
    checkOutput("split_len1", 32'(blens[1]), 32'd16);
    checkOutput("split_len2", 32'(blens[2]), 32'd16);
    checkOutput("split_adr1", badr[1], 32'h0000_1000);
    checkOutput("split_adr2", badr[2], 32'h0000_1040);
    checkOutput("split_cab0", 32'(bcab[0]), 32'd1);
    checkOutput("split_lasts", 32'(countLasts()), 32'd1);
    checkOutput("split_last_pos", 32'(lasts[39]), 32'd1);
    checkOutput("split_done_err", 32'(done_err_seen), 32'd0);

    // Tight page boundary and 32-bit address wrap
    applyStimulus(32'h0000_0FF8, 16'd4, "page");
    waitDone(1'b0, "page");
    checkWords("page", 32'h0000_0FF8, 4);
    checkOutput("page_nbursts", 32'(blens.size()), 32'd2);
    checkOutput("page_len0", 32'(blens[0]), 32'd2);
    applyStimulus(32'hFFFF_FFFA, 16'd4, "wrap");
    waitDone(1'b0, "wrap");
    checkWords("wrap", 32'hFFFF_FFF8, 4);
    checkOutput("wrap_nbursts", 32'(blens.size()), 32'd2);
    checkOutput("wrap_adr1", badr[1], 32'h0000_0000);

    // Backpressure with dat_ready toggling
    applyStimulus(32'h0000_2000, 16'd16, "bp");
    waitDone(1'b1, "bp");
    checkWords("bp", 32'h0000_2000, 16);
    checkOutput("bp_stb_violations", 32'(bp_viol), 32'd0);
    checkOutput("bp_nbursts", 32'(blens.size()), 32'd1);
    checkOutput("bp_lasts", 32'(countLasts()), 32'd1);

    // Single retry on the third strobe
    rty_at = 2;
    applyStimulus(32'h0000_3000, 16'd16, "rty1");
    waitDone(1'b0, "rty1");
    rty_at = -1;
    checkWords("rty1", 32'h0000_3000, 16);
    checkOutput("rty1_nbursts", 32'(blens.size()), 32'd2);
    checkOutput("rty1_len0", 32'(blens[0]), 32'd2);
    checkOutput("rty1_adr1", badr[1], 32'h0000_3008);
    checkOutput("rty1_len1", 32'(blens[1]), 32'd14);
    checkOutput("rty1_done_err", 32'(done_err_seen), 32'd0);

    // Retry on every strobe until the limit
    rty_all = 1'b1;
    applyStimulus(32'h0000_4000, 16'd4, "rtyall");
    waitDone(1'b0, "rtyall");
    rty_all = 1'b0;
    checkOutput("rtyall_rty_count", 32'(rty_seen), 32'd8);
    checkOutput("rtyall_nwords", 32'(words.size()), 32'd0);
    checkOutput("rtyall_done_err", 32'(done_err_seen), 32'd1);
    checkOutput("rtyall_lasts", 32'(countLasts()), 32'd0);

    // Error on the fifth strobe, then a clean command
    err_at = 4;
    applyStimulus(32'h0000_5000, 16'd16, "err");
    waitDone(1'b0, "err");
    err_at = -1;
    checkWords("err", 32'h0000_5000, 4);
    checkOutput("err_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("err_done_err", 32'(done_err_seen), 32'd1);
    checkOutput("err_lasts", 32'(countLasts()), 32'd0);
    applyStimulus(32'h0000_6000, 16'd1, "after_err");
    waitDone(1'b0, "after_err");
    checkWords("after_err", 32'h0000_6000, 1);
    checkOutput("after_err_done_err", 32'(done_err_seen), 32'd0);

    // Asynchronous reset in the middle of a burst
    applyStimulus(32'h0000_7000, 16'd16, "midrst");
    repeat (4) @(posedge clk);
    #2;
    checkOutput("midrst_pre_cyc", 32'(bus.wbm_cyc_o), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    checkOutput("midrst_stb", 32'(bus.wbm_stb_o), 32'd0);
    checkOutput("midrst_dat_valid", 32'(bus.dat_valid), 32'd0);
    checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midrst_ready_after", 32'(bus.cmd_ready), 32'd1);
    checkOutput("midrst_no_done", 32'(done_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
